// File: rtl/mem_stage_vl.sv
// MEM stage: holds a load/store until its variable-latency data_ok, aligns load data, drops flushed responses; optional MEM_FWD_EN adds MEM_fwd.
// Latency >=1 cycle (result may leave in the data_ok cycle); stalls EXE via MEM_allow_in when waiting or when WB_allow_in is low.
module mem_stage_vl #(
  parameter int PC_W      = 32,
  parameter int RF_AW     = 5,
  parameter int MAX_OUTST = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                EXE_MEM_valid,
  output logic                MEM_allow_in,
  input  logic [PC_W-1:0]     EXE_pc,
  input  logic [RF_AW+33:0]   EXE_rf,
  input  logic [6:0]          EXE_load,
  input  logic                EXE_mem_req,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata,
  input  logic                flush,
  input  logic                WB_allow_in,
  output logic                MEM_WB_valid,
  output logic [PC_W-1:0]     MEM_pc,
  output logic [RF_AW+32:0]   MEM_rf
`ifdef MEM_FWD_EN
  ,
  output logic [RF_AW+33:0]   MEM_fwd
`endif
);

  localparam int CW  = $clog2(MAX_OUTST + 1);
  localparam int CW1 = CW + 1;

  logic              valid_q, valid_d;
  logic              mem_req_q, mem_req_d;
  logic              ok_seen_q, ok_seen_d;
  logic [CW-1:0]     discard_cnt_q, discard_cnt_d;
  logic [PC_W-1:0]   pc_q;
  logic [RF_AW+33:0] rf_q;
  logic [5:0]        load_q;
  logic [31:0]       rdata_buf_q;

  logic              ready_go;
  logic              capture;
  logic              own_ok;
  logic              buf_en;
  logic              kill_mem;
  logic              kill_exe;
  logic              dec;
  logic [CW:0]       cnt_nxt_w;
  logic              unused_ld_w;

  assign unused_ld_w  = EXE_load[0];

  assign ready_go     = ~mem_req_q | ok_seen_q | (data_sram_data_ok & (discard_cnt_q == '0));
  assign MEM_allow_in = ~valid_q | (ready_go & WB_allow_in);
  assign MEM_WB_valid = valid_q & ready_go & ~flush;
  assign capture      = EXE_MEM_valid & MEM_allow_in & ~flush;

  // A beat with no discards pending is the MEM instruction's own response.
  assign own_ok   = data_sram_data_ok & (discard_cnt_q == '0) & valid_q & mem_req_q & ~ok_seen_q;
  assign buf_en   = own_ok & ~WB_allow_in;
  assign kill_mem = flush & valid_q & mem_req_q & ~ok_seen_q & ~own_ok;
  assign kill_exe = flush & EXE_MEM_valid & EXE_mem_req;
  assign dec      = data_sram_data_ok & (discard_cnt_q != '0);

  always_comb begin
    cnt_nxt_w     = {1'b0, discard_cnt_q} + CW1'(kill_mem) + CW1'(kill_exe) - CW1'(dec);
    discard_cnt_d = cnt_nxt_w[CW-1:0];

    valid_d   = valid_q;
    mem_req_d = mem_req_q;
    ok_seen_d = ok_seen_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (MEM_allow_in) begin
      valid_d = EXE_MEM_valid;
    end
    if (capture) begin
      mem_req_d = EXE_mem_req;
      ok_seen_d = 1'b0;
    end else if (buf_en) begin
      ok_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      mem_req_q     <= 1'b0;
      ok_seen_q     <= 1'b0;
      discard_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      mem_req_q     <= mem_req_d;
      ok_seen_q     <= ok_seen_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      pc_q   <= EXE_pc;
      rf_q   <= EXE_rf;
      load_q <= EXE_load[6:1];
    end
    if (buf_en) begin
      rdata_buf_q <= data_sram_rdata;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) cnt_nxt_w <= CW1'(MAX_OUTST));

  logic [1:0]  ld_addr;
  logic        ld_hu, ld_bu, ld_h, ld_b;
  logic [31:0] raw;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] aligned;
  logic [31:0] wdata;

  assign ld_addr = load_q[5:4];
  assign ld_hu   = load_q[3];
  assign ld_bu   = load_q[2];
  assign ld_h    = load_q[1];
  assign ld_b    = load_q[0];
  assign raw     = ok_seen_q ? rdata_buf_q : data_sram_rdata;

  always_comb begin
    case (ld_addr)
      2'b00:   byte_sel = raw[7:0];
      2'b01:   byte_sel = raw[15:8];
      2'b10:   byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    half_sel = ld_addr[1] ? raw[31:16] : raw[15:0];
    aligned  = raw;
    if (ld_b | ld_bu) begin
      aligned = {{24{ld_b & byte_sel[7]}}, byte_sel};
    end else if ((ld_h | ld_hu) & ~ld_addr[0]) begin
      aligned = {{16{ld_h & half_sel[15]}}, half_sel};
    end
  end

  assign wdata  = rf_q[RF_AW+33] ? aligned : rf_q[31:0];
  assign MEM_pc = pc_q;
  assign MEM_rf = {rf_q[RF_AW+32] & MEM_WB_valid, rf_q[RF_AW+31:32], wdata};

`ifdef MEM_FWD_EN
  // A load still waiting on data cannot be bypassed; ID must stall on ld_pending.
  assign MEM_fwd = {valid_q & rf_q[RF_AW+33] & ~ready_go, valid_q & rf_q[RF_AW+32], rf_q[RF_AW+31:32], wdata};
`endif

endmodule

// File: tb/tb_mem_stage_vl.sv
// Bench for mem_stage_vl: table of load/store vectors plus hand sequences for stall, flush and reset cases.
module tb_mem_stage_vl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        EXE_MEM_valid = 1'b0;
  logic        MEM_allow_in;
  logic [31:0] EXE_pc = '0;
  logic [38:0] EXE_rf = '0;
  logic [6:0]  EXE_load = '0;
  logic        EXE_mem_req = 1'b0;
  logic        data_sram_data_ok = 1'b0;
  logic [31:0] data_sram_rdata = 32'h5A5A_5A5A;
  logic        flush = 1'b0;
  logic        WB_allow_in = 1'b1;
  logic        MEM_WB_valid;
  logic [31:0] MEM_pc;
  logic [37:0] MEM_rf;

  mem_stage_vl #(.PC_W(32), .RF_AW(5), .MAX_OUTST(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .EXE_MEM_valid(EXE_MEM_valid), .MEM_allow_in(MEM_allow_in),
    .EXE_pc(EXE_pc), .EXE_rf(EXE_rf), .EXE_load(EXE_load), .EXE_mem_req(EXE_mem_req),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .flush(flush), .WB_allow_in(WB_allow_in),
    .MEM_WB_valid(MEM_WB_valid), .MEM_pc(MEM_pc), .MEM_rf(MEM_rf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    logic [6:0]  ld;
    logic        rfm;
    logic        we;
    logic [31:0] alu;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] exp;
  } vec_t;

  exp_t sbq[$];
  int   n_tot = 0;
  int   n_bad = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_exe(input logic [31:0] pc, input logic rfm, input logic we, input logic [4:0] waddr,
                         input logic [31:0] alu, input logic [6:0] ld, input logic req);
    EXE_pc        = pc;
    EXE_rf        = {rfm, we, waddr, alu};
    EXE_load      = ld;
    EXE_mem_req   = req;
    EXE_MEM_valid = 1'b1;
  endtask

  task automatic push(input logic [31:0] pc, input logic we, input logic [4:0] waddr, input logic [31:0] wdata);
    exp_t e;
    e.pc = pc; e.we = we; e.waddr = waddr; e.wdata = wdata;
    sbq.push_back(e);
  endtask

  // Scoreboard: every result accepted by WB must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && MEM_WB_valid && WB_allow_in) begin
      if (sbq.size() == 0) begin
        n_tot++;
        n_bad++;
        $display("FAIL sb_unexpected: got result pc=%h wdata=%h, want none", MEM_pc, MEM_rf[31:0]);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check32("sb_pc", MEM_pc, e.pc);
        check1("sb_we", MEM_rf[37], e.we);
        check32("sb_waddr", 32'(MEM_rf[36:32]), 32'(e.waddr));
        check32("sb_wdata", MEM_rf[31:0], e.wdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1, "timeout");
  end

  vec_t tv[10];

  initial begin
    // {addr[1:0], ld_hu, ld_bu, ld_h, ld_b, ld_w}
    tv[0] = '{7'b11_00010, 1'b1, 1'b1, 32'h0,         32'h80AB_CD12, 3, 32'hFFFF_FF80};
    tv[1] = '{7'b01_01000, 1'b1, 1'b1, 32'h0,         32'h80AB_CD12, 0, 32'h0000_00CD};
    tv[2] = '{7'b00_00010, 1'b1, 1'b1, 32'h0,         32'h1234_5678, 1, 32'h0000_0078};
    tv[3] = '{7'b00_00100, 1'b1, 1'b1, 32'h0,         32'h1234_F00D, 2, 32'hFFFF_F00D};
    tv[4] = '{7'b10_00100, 1'b1, 1'b1, 32'h0,         32'h8001_0000, 0, 32'hFFFF_8001};
    tv[5] = '{7'b10_10000, 1'b1, 1'b1, 32'h0,         32'h9876_0000, 1, 32'h0000_9876};
    tv[6] = '{7'b01_00100, 1'b1, 1'b1, 32'h0,         32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
    tv[7] = '{7'b00_00001, 1'b1, 1'b1, 32'h0,         32'hCAFE_F00D, 2, 32'hCAFE_F00D};
    tv[8] = '{7'b00_00000, 1'b0, 1'b0, 32'h0000_1000, 32'h7777_7777, 1, 32'h0000_1000};
    tv[9] = '{7'b10_01000, 1'b1, 1'b1, 32'h0,         32'h1122_3344, 0, 32'h0000_0022};

    #2;
    check1("rst_wb_valid", MEM_WB_valid, 1'b0);
    check1("rst_allow_in", MEM_allow_in, 1'b1);
    check1("rst_we", MEM_rf[37], 1'b0);
    check32("rst_discard", 32'(dut.discard_cnt_q), 32'd0);
    tick;
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 10; i++) begin
      WB_allow_in = 1'b1;
      set_exe(32'h1000 + 32'(i * 4), tv[i].rfm, tv[i].we, 5'(i + 1), tv[i].alu, tv[i].ld, 1'b1);
      #1 check1("tv_allow_in", MEM_allow_in, 1'b1);
      tick;
      push(32'h1000 + 32'(i * 4), tv[i].we, 5'(i + 1), tv[i].exp);
      EXE_MEM_valid = 1'b0;
      for (int c = 0; c < tv[i].lat; c++) begin
        #1 check1("tv_wait_valid", MEM_WB_valid, 1'b0);
        check1("tv_wait_allow", MEM_allow_in, 1'b0);
        tick;
      end
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = tv[i].rdata;
      #1 check1("tv_done_valid", MEM_WB_valid, 1'b1);
      tick;
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'h5A5A_5A5A;
    end

    // ld.hu answered while WB stalls: the buffered word must survive rdata changing.
    set_exe(32'h2000, 1'b1, 1'b1, 5'd20, 32'h0, 7'b10_10000, 1'b1);
    tick;
    push(32'h2000, 1'b1, 5'd20, 32'h0000_9876);
    EXE_MEM_valid     = 1'b0;
    WB_allow_in       = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h9876_0000;
    #1 check1("buf_ok_valid", MEM_WB_valid, 1'b1);
    check1("buf_ok_allow", MEM_allow_in, 1'b0);
    tick;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hFFFF_FFFF;
    #1 check1("buf_hold_valid", MEM_WB_valid, 1'b1);
    check32("buf_hold_wdata", MEM_rf[31:0], 32'h0000_9876);
    tick;
    WB_allow_in = 1'b1;
    #1 check1("buf_free_allow", MEM_allow_in, 1'b1);
    tick;

    // Flush with a waiting load and a requesting EXE instr: two responses to discard.
    set_exe(32'h3000, 1'b1, 1'b1, 5'd5, 32'h0, 7'b00_00001, 1'b1);
    tick;
    EXE_MEM_valid = 1'b0;
    tick;
    set_exe(32'h3004, 1'b1, 1'b1, 5'd6, 32'h0, 7'b00_00001, 1'b1);
    flush = 1'b1;
    #1 check1("fl_wb_valid", MEM_WB_valid, 1'b0);
    tick;
    flush         = 1'b0;
    EXE_MEM_valid = 1'b0;
    check32("fl_discard2", 32'(dut.discard_cnt_q), 32'd2);
    set_exe(32'h3008, 1'b1, 1'b1, 5'd7, 32'h0, 7'b00_00001, 1'b1);
    #1 check1("fl_allow_in", MEM_allow_in, 1'b1);
    tick;
    push(32'h3008, 1'b1, 5'd7, 32'hCAFE_0001);
    EXE_MEM_valid     = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_1111;
    #1 check1("fl_drop1_valid", MEM_WB_valid, 1'b0);
    tick;
    check32("fl_discard1", 32'(dut.discard_cnt_q), 32'd1);
    data_sram_rdata = 32'h2222_2222;
    #1 check1("fl_drop2_valid", MEM_WB_valid, 1'b0);
    tick;
    check32("fl_discard0", 32'(dut.discard_cnt_q), 32'd0);
    data_sram_rdata = 32'hCAFE_0001;
    #1 check1("fl_third_valid", MEM_WB_valid, 1'b1);
    tick;
    data_sram_data_ok = 1'b0;

    // Flush in the same cycle as the load's own data_ok: nothing left to discard.
    set_exe(32'h4000, 1'b1, 1'b1, 5'd8, 32'h0, 7'b00_00001, 1'b1);
    tick;
    EXE_MEM_valid     = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_DEAD;
    flush             = 1'b1;
    #1 check1("flok_wb_valid", MEM_WB_valid, 1'b0);
    check1("flok_we", MEM_rf[37], 1'b0);
    tick;
    data_sram_data_ok = 1'b0;
    flush             = 1'b0;
    #1 check32("flok_discard", 32'(dut.discard_cnt_q), 32'd0);
    check1("flok_allow_in", MEM_allow_in, 1'b1);
    check1("flok_after_valid", MEM_WB_valid, 1'b0);
    tick;

    // ALU ops back to back: one result per cycle.
    for (int k = 0; k < 4; k++) begin
      set_exe(32'h5000 + 32'(k * 4), 1'b0, 1'b1, 5'(k + 10), 32'hA000_0000 + 32'(k), 7'b00_00001, 1'b0);
      #1 check1("alu_allow_in", MEM_allow_in, 1'b1);
      if (k > 0) check1("alu_b2b_valid", MEM_WB_valid, 1'b1);
      tick;
      push(32'h5000 + 32'(k * 4), 1'b1, 5'(k + 10), 32'hA000_0000 + 32'(k));
    end
    EXE_MEM_valid = 1'b0;
    #1 check1("alu_last_valid", MEM_WB_valid, 1'b1);
    tick;

    // Reset while a load waits behind pending discards.
    set_exe(32'h6000, 1'b1, 1'b1, 5'd9, 32'h0, 7'b00_00001, 1'b1);
    tick;
    set_exe(32'h6004, 1'b1, 1'b1, 5'd9, 32'h0, 7'b00_00001, 1'b1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    set_exe(32'h6008, 1'b1, 1'b1, 5'd9, 32'h0, 7'b00_00001, 1'b1);
    tick;
    EXE_MEM_valid = 1'b0;
    tick;
    check32("pre_rst_discard", 32'(dut.discard_cnt_q), 32'd2);
    rst_n = 1'b0;
    #1 check1("mrst_wb_valid", MEM_WB_valid, 1'b0);
    check32("mrst_discard", 32'(dut.discard_cnt_q), 32'd0);
    check1("mrst_allow_in", MEM_allow_in, 1'b1);
    check1("mrst_we", MEM_rf[37], 1'b0);
    tick;
    rst_n = 1'b1;
    tick;
    set_exe(32'h7000, 1'b0, 1'b1, 5'd3, 32'h1234_5678, 7'b00_00001, 1'b0);
    tick;
    push(32'h7000, 1'b1, 5'd3, 32'h1234_5678);
    EXE_MEM_valid = 1'b0;
    #1 check1("post_rst_valid", MEM_WB_valid, 1'b1);
    tick;
    tick;

    check32("sb_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
